// File: rtl/abs_diff_accum_pkg.sv
// Shared definitions for the streaming sum-of-absolute-differences engine.
// State encodings are plain 2-bit constants so legacy code can compare against them directly.
package abs_diff_accum_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Accumulator width: COUNT samples of at most 2^WIDTH-1 each can never overflow it.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned count);
    return width + $clog2(count);
  endfunction

endpackage

// File: rtl/abs_diff_core.sv
// Combinational |a-b| for unsigned or two's-complement operands.
// The true difference always fits in WIDTH unsigned bits, so WIDTH-bit subtraction is exact.
module abs_diff_core #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic           a_ge_b;

  // One extra bit lets a single signed compare serve both operand modes.
  always_comb begin
    a_ext  = {((SIGNED != 0) ? a[WIDTH-1] : 1'b0), a};
    b_ext  = {((SIGNED != 0) ? b[WIDTH-1] : 1'b0), b};
    a_ge_b = $signed(a_ext) >= $signed(b_ext);
    diff   = a_ge_b ? (a - b) : (b - a);
  end

endmodule

// File: rtl/abs_diff_accum.sv
// Streaming SAD engine: accepts COUNT (a,b) pairs per frame, reports sum and max of |a-b|.
// Two-stage pipeline (diff register, then accumulate) behind a four-state frame FSM.
module abs_diff_accum
  import abs_diff_accum_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned COUNT  = 8,
  parameter int unsigned SIGNED = 0,
  localparam int unsigned ACC_W = acc_width(WIDTH, COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sad,
  output logic [WIDTH-1:0] max_diff
);

  localparam int unsigned CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(COUNT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_diff_q;
  logic [WIDTH-1:0] diff;
  logic [ACC_W-1:0] sad_q;
  logic [WIDTH-1:0] max_q;
  logic             accept;
  logic             frame_ack;

  abs_diff_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .a    (a),
    .b    (b),
    .diff (diff)
  );

  assign in_ready  = (state_q == StIdle) || (state_q == StAccum);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;
  assign frame_ack = out_valid && out_ready;
  assign sad       = sad_q;
  assign max_diff  = max_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          count_d = CNT_W'(1);
          state_d = (COUNT == 1) ? StDrain : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == LastCnt) state_d = StDrain;
        end
      end
      // Wait until the last diff has been folded into the accumulator.
      StDrain: begin
        if (!s1_valid_q) state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      sad_q      <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      s1_valid_q <= accept;
      if (accept) s1_diff_q <= diff;
      if (frame_ack) begin
        sad_q <= '0;
        max_q <= '0;
      end else if (s1_valid_q) begin
        sad_q <= sad_q + ACC_W'(s1_diff_q);
        if (s1_diff_q > max_q) max_q <= s1_diff_q;
      end
    end
  end

endmodule

// File: tb/tb_abs_diff_accum.sv
// Directed bench: unsigned and signed COUNT=4 engines share stimulus; a COUNT=1 engine runs alone.
module tb_abs_diff_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       out_ready = 1'b0;

  logic       u_in_ready, u_out_valid;
  logic [5:0] u_sad;
  logic [3:0] u_max;
  logic       s_in_ready, s_out_valid;
  logic [5:0] s_sad;
  logic [3:0] s_max;

  logic       c1_valid = 1'b0;
  logic [3:0] c1_a = '0;
  logic [3:0] c1_b = '0;
  logic       c1_out_ready = 1'b0;
  logic       c1_in_ready, c1_out_valid;
  logic [3:0] c1_sad;
  logic [3:0] c1_max;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  abs_diff_accum #(.WIDTH(4), .COUNT(4), .SIGNED(0)) u_dut_u (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (u_in_ready), .a (a), .b (b),
    .out_valid (u_out_valid), .out_ready (out_ready), .sad (u_sad), .max_diff (u_max)
  );

  abs_diff_accum #(.WIDTH(4), .COUNT(4), .SIGNED(1)) u_dut_s (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (s_in_ready), .a (a), .b (b),
    .out_valid (s_out_valid), .out_ready (out_ready), .sad (s_sad), .max_diff (s_max)
  );

  abs_diff_accum #(.WIDTH(4), .COUNT(1), .SIGNED(0)) u_dut_c1 (
    .clk (clk), .rst (rst), .in_valid (c1_valid), .in_ready (c1_in_ready), .a (c1_a),
    .b (c1_b), .out_valid (c1_out_valid), .out_ready (c1_out_ready), .sad (c1_sad),
    .max_diff (c1_max)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed four pairs (element i in nibble i); optional idle cycle before each pair after the first.
  task automatic feed(input logic [15:0] av, input logic [15:0] bv, input bit bubbles);
    for (int i = 0; i < 4; i++) begin
      if (bubbles && i > 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      a = av[i*4 +: 4];
      b = bv[i*4 +: 4];
      step();
    end
    in_valid = 1'b0;
  endtask

  // Called #1 after the last accept edge: result must appear exactly two edges later.
  task automatic expect_result(input string tag, input int usad, input int umax,
                               input int ssad, input int smax);
    check({tag, " ov t+0"}, 32'(u_out_valid), 0);
    step();
    check({tag, " ov t+1"}, 32'(u_out_valid), 0);
    step();
    check({tag, " ov t+2"}, 32'(u_out_valid), 1);
    check({tag, " in_ready"}, 32'(u_in_ready), 0);
    check({tag, " u sad"}, 32'(u_sad), 32'(usad));
    check({tag, " u max"}, 32'(u_max), 32'(umax));
    check({tag, " s sad"}, 32'(s_sad), 32'(ssad));
    check({tag, " s max"}, 32'(s_max), 32'(smax));
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " ov after ack"}, 32'(u_out_valid), 0);
    check({tag, " sad after ack"}, 32'(u_sad), 0);
    check({tag, " in_ready after ack"}, 32'(u_in_ready), 1);
  endtask

  initial begin
    // 1. Reset
    #2;
    check("rst ov", 32'(u_out_valid), 0);
    check("rst sad", 32'(u_sad), 0);
    check("rst max", 32'(u_max), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rst in_ready", 32'(u_in_ready), 1);

    // 2. Unsigned back-to-back; signed engine sees 3-7,-7-2,-1-0,0-0
    feed({4'd0, 4'd15, 4'd9, 4'd3}, {4'd0, 4'd0, 4'd2, 4'd7}, 1'b0);
    expect_result("t2", 26, 15, 14, 9);
    ack("t2");

    // 3. Signed {-8,-1,5,-3} vs {7,1,5,-7}
    feed({4'hD, 4'h5, 4'hF, 4'h8}, {4'h9, 4'h5, 4'h1, 4'h7}, 1'b0);
    expect_result("t3", 19, 14, 21, 15);
    ack("t3");

    // 4. Bubbles, then held result under backpressure
    feed({4'd0, 4'd15, 4'd9, 4'd3}, {4'd0, 4'd0, 4'd2, 4'd7}, 1'b1);
    expect_result("t4", 26, 15, 14, 9);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 4'd15;
      b = 4'd0;
      step();
    end
    in_valid = 1'b0;
    check("t4 held ov", 32'(u_out_valid), 1);
    check("t4 held sad", 32'(u_sad), 26);
    check("t4 held max", 32'(u_max), 15);
    check("t4 held in_ready", 32'(u_in_ready), 0);
    ack("t4");
    feed({4'd1, 4'd1, 4'd1, 4'd1}, 16'h0000, 1'b0);
    expect_result("t4b", 4, 1, 4, 1);
    ack("t4b");

    // 5. Reset after two accepts discards the partial frame
    in_valid = 1'b1;
    a = 4'd15;
    b = 4'd0;
    step();
    step();
    in_valid = 1'b0;
    step();
    #1 rst = 1'b1;
    #1;
    check("t5 rst ov", 32'(u_out_valid), 0);
    check("t5 rst sad", 32'(u_sad), 0);
    check("t5 rst max", 32'(u_max), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    feed({4'd2, 4'd2, 4'd2, 4'd2}, 16'h0000, 1'b0);
    expect_result("t5", 8, 2, 8, 2);
    ack("t5");

    // 6. Full-scale operands: no wrap in 6-bit sum; signed sees -1-0
    feed(16'hFFFF, 16'h0000, 1'b0);
    expect_result("t6", 60, 15, 4, 1);
    ack("t6");

    // COUNT=1 engine
    c1_valid = 1'b1;
    c1_a = 4'd5;
    c1_b = 4'd9;
    step();
    c1_valid = 1'b0;
    check("c1 in_ready", 32'(c1_in_ready), 0);
    check("c1 ov t+0", 32'(c1_out_valid), 0);
    step();
    check("c1 ov t+1", 32'(c1_out_valid), 0);
    step();
    check("c1 ov t+2", 32'(c1_out_valid), 1);
    check("c1 sad", 32'(c1_sad), 4);
    check("c1 max", 32'(c1_max), 4);
    c1_out_ready = 1'b1;
    step();
    c1_out_ready = 1'b0;
    check("c1 ov after ack", 32'(c1_out_valid), 0);
    check("c1 in_ready after ack", 32'(c1_in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
